gpr_cdb_arb: RTL and testbench

Round-robin arbiter that shares the single GPR common data bus (CDB) between N_REQ result producers (in unit, ALU, FPU, load unit, ...). Each cycle it grants at most one requester, completes that requester's valid/ready handshake, and broadcasts the winner's tag/data on a registered CDB one cycle later. It sits between the execution units' `gpr_cdb_req` handshakes and the ROB/reservation-station CDB snoop logic.

---
 rtl/gpr_cdb_arb_pkg.sv | 18 +
 rtl/gpr_cdb_arb_if.sv | 24 ++
 rtl/gpr_cdb_arb_rr_pick.sv | 37 +++
 rtl/gpr_cdb_arb.sv | 77 +++++++
 tb/tb_gpr_cdb_arb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/gpr_cdb_arb_pkg.sv
// Shared types for the GPR common data bus arbiter: CDB payload layout and
// the modular index helper used by the rotating-priority picker.
package gpr_cdb_arb_pkg;

    localparam int ROB_WIDTH  = 6;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

    // Wraps an index in [0, 2n) back into [0, n); works for any n, not only powers of two.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/gpr_cdb_arb_if.sv
// Per-requester valid/ready/data bundle between the result producers and the
// GPR CDB arbiter.
interface gpr_cdb_arb_if #(
    parameter int N_REQ = 4
);
    import gpr_cdb_arb_pkg::*;

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    cdb_t [N_REQ-1:0] req_data;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/gpr_cdb_arb_rr_pick.sv
// Purely combinational rotating-priority picker: first set bit of valid_i
// scanning cyclically upward from start_i.
module gpr_cdb_arb_rr_pick
    import gpr_cdb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] pos;
    logic             hit;
    logic             found;

    // Scan offsets 0..N_REQ-1 from the start pointer; the first hit wins.
    always_comb begin
        grant_o = {N_REQ{1'b0}};
        idx_o   = {PTR_W{1'b0}};
        found   = 1'b0;
        pos     = {PTR_W{1'b0}};
        hit     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos          = PTR_W'(rr_wrap(int'(start_i) + k, N_REQ));
            hit          = ~found & valid_i[pos];
            grant_o[pos] = grant_o[pos] | hit;
            idx_o        = hit ? pos : idx_o;
            found        = found | hit;
        end
        any_o = found;
    end

endmodule

// File: rtl/gpr_cdb_arb.sv
// Round-robin arbiter for the single GPR CDB: grants one producer per cycle
// and broadcasts its tag/data from a register on the following cycle.
module gpr_cdb_arb
    import gpr_cdb_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    gpr_cdb_arb_if.slave        req_if,
    input  logic                flush,
    output logic                cdb_valid,
    output cdb_t                cdb
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    cdb_t             cdb_q, cdb_d;

    logic [N_REQ-1:0] pick_grant;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant_ok;
    logic [N_REQ-1:0] req_ready_s;

    gpr_cdb_arb_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid_i (req_if.req_valid),
        .start_i (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant gating, pointer advance and next broadcast; ready is masked while in reset.
    always_comb begin
        grant_ok    = pick_any & ~flush & rst_n;
        req_ready_s = {N_REQ{1'b0}};
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_d       = cdb_q;
        if (grant_ok) begin
            req_ready_s = pick_grant;
            rr_ptr_d    = (pick_idx == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}}
                                                          : (pick_idx + PTR_W'(1));
            cdb_valid_d = 1'b1;
            cdb_d       = req_if.req_data[pick_idx];
        end else begin
            req_ready_s = {N_REQ{1'b0}};
            rr_ptr_d    = rr_ptr_q;
            cdb_valid_d = 1'b0;
            cdb_d       = cdb_q;
        end
    end

    // Pointer and CDB output register; reset drops any pending broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= {PTR_W{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_q       <= cdb_t'({(ROB_WIDTH + DATA_WIDTH){1'b0}});
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

    assign req_if.req_ready = req_ready_s;
    assign cdb_valid        = cdb_valid_q;
    assign cdb              = cdb_q;

endmodule

// File: tb/tb_gpr_cdb_arb.sv
// Directed, table-driven bench for gpr_cdb_arb with a 4-requester and a
// 3-requester instance (the latter exercises non-power-of-two wrap).
module tb_gpr_cdb_arb;
    import gpr_cdb_arb_pkg::*;

    typedef struct {
        logic [3:0]           valid;
        logic                 flush;
        logic [ROB_WIDTH-1:0] tag_base;
        logic [31:0]          data_base;
        logic [3:0]           exp_ready;
        logic                 exp_cv;
        logic [ROB_WIDTH-1:0] exp_tag;
        logic [31:0]          exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush4, flush3;
    logic cv4, cv3;
    cdb_t cdb4, cdb3;
    int   checks = 0;
    int   errors = 0;

    vec_t v4 [18];
    vec_t v3 [6];

    gpr_cdb_arb_if #(.N_REQ(4)) if4 ();
    gpr_cdb_arb_if #(.N_REQ(3)) if3 ();

    gpr_cdb_arb #(.N_REQ(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (if4.slave),
        .flush     (flush4),
        .cdb_valid (cv4),
        .cdb       (cdb4)
    );

    gpr_cdb_arb #(.N_REQ(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (if3.slave),
        .flush     (flush3),
        .cdb_valid (cv3),
        .cdb       (cdb3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester i presents tag = tag_base + i and data = data_base ^ i.
    task automatic run_vec(input vec_t v, input bit use3, input int n);
        if (use3) begin
            if3.req_valid = v.valid[2:0];
            flush3        = v.flush;
            for (int i = 0; i < 3; i++) begin
                if3.req_data[i].tag  = v.tag_base + ROB_WIDTH'(i);
                if3.req_data[i].data = v.data_base ^ 32'(i);
            end
        end else begin
            if4.req_valid = v.valid;
            flush4        = v.flush;
            for (int i = 0; i < 4; i++) begin
                if4.req_data[i].tag  = v.tag_base + ROB_WIDTH'(i);
                if4.req_data[i].data = v.data_base ^ 32'(i);
            end
        end
        @(negedge clk);
        if (use3) begin
            chk($sformatf("n3[%0d] ready", n), 64'(if3.req_ready), 64'(v.exp_ready));
            chk($sformatf("n3[%0d] cdb_valid", n), 64'(cv3), 64'(v.exp_cv));
            chk($sformatf("n3[%0d] tag", n), 64'(cdb3.tag), 64'(v.exp_tag));
            chk($sformatf("n3[%0d] data", n), 64'(cdb3.data), 64'(v.exp_data));
        end else begin
            chk($sformatf("n4[%0d] ready", n), 64'(if4.req_ready), 64'(v.exp_ready));
            chk($sformatf("n4[%0d] cdb_valid", n), 64'(cv4), 64'(v.exp_cv));
            chk($sformatf("n4[%0d] tag", n), 64'(cdb4.tag), 64'(v.exp_tag));
            chk($sformatf("n4[%0d] data", n), 64'(cdb4.data), 64'(v.exp_data));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid, flush, tag_base, data_base, exp_ready, exp_cv, exp_tag, exp_data
        v4[0]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0001, 1'b0, 6'h00, 32'h0000_0000};
        v4[1]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0010, 1'b1, 6'h10, 32'h1000_0000};
        v4[2]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0100, 1'b1, 6'h11, 32'h1000_0001};
        v4[3]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b1000, 1'b1, 6'h12, 32'h1000_0002};
        v4[4]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0001, 1'b1, 6'h13, 32'h1000_0003};
        v4[5]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0010, 1'b1, 6'h10, 32'h1000_0000};
        v4[6]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b0100, 1'b1, 6'h11, 32'h1000_0001};
        v4[7]  = '{4'b1111, 1'b0, 6'h10, 32'h1000_0000, 4'b1000, 1'b1, 6'h12, 32'h1000_0002};
        v4[8]  = '{4'b0000, 1'b0, 6'h10, 32'h1000_0000, 4'b0000, 1'b1, 6'h13, 32'h1000_0003};
        v4[9]  = '{4'b0000, 1'b0, 6'h10, 32'h1000_0000, 4'b0000, 1'b0, 6'h13, 32'h1000_0003};
        v4[10] = '{4'b0100, 1'b0, 6'h03, 32'hDEAD_BEED, 4'b0100, 1'b0, 6'h13, 32'h1000_0003};
        v4[11] = '{4'b1111, 1'b0, 6'h20, 32'h2000_0000, 4'b1000, 1'b1, 6'h05, 32'hDEAD_BEEF};
        v4[12] = '{4'b0011, 1'b1, 6'h20, 32'h2000_0000, 4'b0000, 1'b1, 6'h23, 32'h2000_0003};
        v4[13] = '{4'b0011, 1'b0, 6'h20, 32'h2000_0000, 4'b0001, 1'b0, 6'h23, 32'h2000_0003};
        v4[14] = '{4'b0011, 1'b0, 6'h20, 32'h2000_0000, 4'b0010, 1'b1, 6'h20, 32'h2000_0000};
        v4[15] = '{4'b0001, 1'b0, 6'h20, 32'h2000_0000, 4'b0001, 1'b1, 6'h21, 32'h2000_0001};
        v4[16] = '{4'b1000, 1'b0, 6'h30, 32'h3000_0000, 4'b1000, 1'b1, 6'h20, 32'h2000_0000};
        v4[17] = '{4'b0000, 1'b0, 6'h30, 32'h3000_0000, 4'b0000, 1'b1, 6'h33, 32'h3000_0003};

        v3[0]  = '{4'b0011, 1'b0, 6'h08, 32'hA000_0000, 4'b0001, 1'b0, 6'h00, 32'h0000_0000};
        v3[1]  = '{4'b0010, 1'b0, 6'h08, 32'hA000_0000, 4'b0010, 1'b1, 6'h08, 32'hA000_0000};
        v3[2]  = '{4'b0101, 1'b0, 6'h08, 32'hA000_0000, 4'b0100, 1'b1, 6'h09, 32'hA000_0001};
        v3[3]  = '{4'b0101, 1'b0, 6'h08, 32'hA000_0000, 4'b0001, 1'b1, 6'h0A, 32'hA000_0002};
        v3[4]  = '{4'b0101, 1'b0, 6'h08, 32'hA000_0000, 4'b0100, 1'b1, 6'h08, 32'hA000_0000};
        v3[5]  = '{4'b0000, 1'b0, 6'h08, 32'hA000_0000, 4'b0000, 1'b1, 6'h0A, 32'hA000_0002};

        // Reset held with every requester valid.
        rst_n         = 1'b0;
        flush4        = 1'b0;
        flush3        = 1'b0;
        if4.req_valid = 4'b1111;
        if3.req_valid = 3'b111;
        if4.req_data  = '0;
        if3.req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset ready4", 64'(if4.req_ready), 64'h0);
        chk("reset ready3", 64'(if3.req_ready), 64'h0);
        chk("reset cdb_valid", 64'(cv4), 64'h0);
        chk("reset tag", 64'(cdb4.tag), 64'h0);
        chk("reset data", 64'(cdb4.data), 64'h0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        if3.req_valid = 3'b000;

        for (int n = 0; n < 18; n++) begin
            run_vec(v4[n], 1'b0, n);
        end

        // Mid-operation reset: the broadcast of requester 1 is dropped at once.
        if4.req_valid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            if4.req_data[i].tag  = 6'h06 + ROB_WIDTH'(i);
            if4.req_data[i].data = 32'h7777_0000 ^ 32'(i);
        end
        @(negedge clk);
        chk("midrst grant", 64'(if4.req_ready), 64'h2);
        @(posedge clk);
        #1;
        chk("midrst cdb_valid pre", 64'(cv4), 64'h1);
        chk("midrst tag pre", 64'(cdb4.tag), 64'h7);
        chk("midrst data pre", 64'(cdb4.data), 64'h7777_0001);
        rst_n = 1'b0;
        #1;
        chk("midrst cdb_valid", 64'(cv4), 64'h0);
        chk("midrst tag", 64'(cdb4.tag), 64'h0);
        chk("midrst ready", 64'(if4.req_ready), 64'h0);
        @(posedge clk);
        #1;
        if4.req_valid = 4'b1111;
        rst_n         = 1'b1;
        @(negedge clk);
        chk("postrst grant", 64'(if4.req_ready), 64'h1);
        chk("postrst cdb_valid", 64'(cv4), 64'h0);
        @(posedge clk);
        #1;
        if4.req_valid = 4'b0000;

        for (int n = 0; n < 6; n++) begin
            run_vec(v3[n], 1'b1, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
